// File: rtl/cmp_pkg.sv
// Shared definitions for the BETA ALU compare unit: function codes,
// flag bit positions and the flag-to-boolean select.
package cmp_pkg;

    // Compare function codes (3'b000 and 3'b100 are reserved -> result 0)
    localparam logic [2:0] CFN_EQ  = 3'b001;
    localparam logic [2:0] CFN_LT  = 3'b010;
    localparam logic [2:0] CFN_LE  = 3'b011;
    localparam logic [2:0] CFN_NE  = 3'b101;
    localparam logic [2:0] CFN_LTU = 3'b110;
    localparam logic [2:0] CFN_LEU = 3'b111;

    // Bit positions inside the {Z,V,N,C} flag vector
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 0;

    // Boolean compare outcome from A-B flags; C=1 means no borrow (a >= b unsigned)
    function automatic logic cmp_select(input logic [3:0] fl, input logic [2:0] fn);
        logic z, v, n, c;
        z = fl[FLAG_Z];
        v = fl[FLAG_V];
        n = fl[FLAG_N];
        c = fl[FLAG_C];
        case (fn)
            CFN_EQ:  return z;
            CFN_LT:  return n ^ v;
            CFN_LE:  return z | (n ^ v);
            CFN_NE:  return ~z;
            CFN_LTU: return ~c;
            CFN_LEU: return ~c | z;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cmp_flags.sv
// Combinational Z/V/N/C flag generator for A-B; shared with the ARITH unit.
module cmp_flags #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             z,
    output logic             v,
    output logic             n,
    output logic             c
);

    logic [WIDTH:0] diff;

    // Two's-complement subtract with the carry-out kept as the no-borrow flag
    always_comb begin
        diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        c    = diff[WIDTH];
        z    = (diff[WIDTH-1:0] == '0);
        n    = diff[WIDTH-1];
        v    = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/cmp_pipe.sv
// Two-stage pipelined compare unit with valid/ready handshake.
// Stage 1 captures the flags of A-B with cfn/tag; stage 2 selects the
// boolean and presents result/flags/tag to the writeback consumer.
module cmp_pipe
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned TAG_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           cfn,
    input  logic [TAG_W-1:0]     tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] result,
    output logic [3:0]           flags,
    output logic [TAG_W-1:0]     tag_out
);

    logic             fz, fv, fn, fc;
    logic             s1_valid;
    logic [3:0]       s1_flags;
    logic [2:0]       s1_cfn;
    logic [TAG_W-1:0] s1_tag;
    logic             adv2;
    logic             accept;
    logic [OUT_WIDTH-1:0] result_d;

    cmp_flags #(
        .WIDTH(WIDTH)
    ) u_flags (
        .a(a),
        .b(b),
        .z(fz),
        .v(fv),
        .n(fn),
        .c(fc)
    );

    // Handshake: stage 2 frees up when empty or draining; stage 1 when empty or moving on
    always_comb begin
        adv2     = !out_valid | out_ready;
        in_ready = !s1_valid | adv2;
        accept   = in_valid & in_ready;
    end

    // Zero-extended boolean from the stage-1 flags
    always_comb begin
        result_d    = '0;
        result_d[0] = cmp_select(s1_flags, s1_cfn);
    end

    // Stage 1: capture flags, function code and tag on input transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_flags <= '0;
            s1_cfn   <= '0;
            s1_tag   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_flags <= {fz, fv, fn, fc};
            s1_cfn   <= cfn;
            s1_tag   <= tag_in;
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: register the selected result; payload holds while stalled or empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            tag_out   <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result  <= result_d;
                flags   <= s1_flags;
                tag_out <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_cmp_pipe.sv
// Scoreboard bench for cmp_pipe: directed vectors with hand-computed
// results/flags are queued on input transfer and checked by a monitor
// on each output transfer.
module tb_cmp_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  cfn;
    logic [4:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [4:0]  tag_out;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        logic [4:0]  tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned xfer_cyc[$];
    int unsigned cyc;
    int unsigned checks;
    int unsigned passes;

    cmp_pipe #(
        .WIDTH(32),
        .OUT_WIDTH(32),
        .TAG_W(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .cfn(cfn),
        .tag_in(tag_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .flags(flags),
        .tag_out(tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Monitor: a transfer happens at the next rising edge when valid & ready at the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                xfer_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("unexpected_output", {59'd0, tag_out}, 64'h1F_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("result", {32'd0, result}, {32'd0, e.res});
                    chk("flags", {60'd0, flags}, {60'd0, e.fl});
                    chk("tag_out", {59'd0, tag_out}, {59'd0, e.tag});
                end
            end
        end
    end

    // Present one op; returns at posedge+1 after the accepting edge with in_valid low
    task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic [2:0] vf,
                        input logic [4:0] vt, input logic [31:0] eres, input logic [3:0] efl);
        exp_t e;
        bit   done;
        a        = va;
        b        = vb;
        cfn      = vf;
        tag_in   = vt;
        in_valid = 1'b1;
        done     = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.res = eres;
                e.fl  = efl;
                e.tag = vt;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [2:0]  vf;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    vec_t stream[8];

    initial begin
        checks    = 0;
        passes    = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cfn       = '0;
        tag_in    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_payload", {23'd0, result, flags, tag_out}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // 1: EQ with latency, then NE
        send(32'd5, 32'd5, 3'b001, 5'd1, 32'd1, 4'b1001);
        @(negedge clk);
        chk("lat_edge1_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("lat_edge2_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;
        send(32'd5, 32'd5, 3'b101, 5'd2, 32'd0, 4'b1001);
        drain();

        // 2: signed/unsigned wrap cases
        send(32'h8000_0000, 32'h0000_0001, 3'b010, 5'd3, 32'd1, 4'b0101);
        send(32'h8000_0000, 32'h0000_0001, 3'b110, 5'd4, 32'd0, 4'b0101);
        send(32'hFFFF_FFFF, 32'h0000_0000, 3'b010, 5'd5, 32'd1, 4'b0011);
        send(32'hFFFF_FFFF, 32'h0000_0000, 3'b111, 5'd6, 32'd0, 4'b0011);
        drain();

        // 3: back-to-back stream, tags 0..7
        stream[0] = '{32'd0, 32'd3, 3'b110, 32'd1, 4'b0010};
        stream[1] = '{32'd1, 32'd3, 3'b010, 32'd1, 4'b0010};
        stream[2] = '{32'd2, 32'd3, 3'b011, 32'd1, 4'b0010};
        stream[3] = '{32'd3, 32'd3, 3'b001, 32'd1, 4'b1001};
        stream[4] = '{32'd4, 32'd3, 3'b101, 32'd1, 4'b0001};
        stream[5] = '{32'd5, 32'd3, 3'b111, 32'd0, 4'b0001};
        stream[6] = '{32'd6, 32'd3, 3'b010, 32'd0, 4'b0001};
        stream[7] = '{32'd7, 32'd3, 3'b110, 32'd0, 4'b0001};
        xfer_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            logic [4:0] t;
            t = 5'(i);
            send(stream[i].va, stream[i].vb, stream[i].vf, t, stream[i].res, stream[i].fl);
        end
        drain();
        chk("stream_count", 64'(xfer_cyc.size()), 64'd8);
        if (xfer_cyc.size() == 8)
            chk("stream_span", 64'(xfer_cyc[7] - xfer_cyc[0]), 64'd7);

        // 4: fill under stall, then one-cycle release
        out_ready = 1'b0;
        send(32'd10, 32'd20, 3'b010, 5'd10, 32'd1, 4'b0010);
        send(32'd20, 32'd10, 3'b111, 5'd11, 32'd0, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_in_ready", {63'd0, in_ready}, 64'd0);
            chk("held_payload", {23'd0, out_valid, result, flags, tag_out},
                {23'd0, 1'b1, 32'd1, 4'b0010, 5'd10});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 5'd12, 32'd1, 4'b1001);
        out_ready = 1'b0;
        @(negedge clk);
        chk("after_one_xfer", {57'd0, out_valid, in_ready, tag_out}, {57'd0, 1'b1, 1'b0, 5'd11});
        chk("after_one_sb", 64'(sb.size()), 64'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // 5: asynchronous reset with two ops in flight
        send(32'd1, 32'd2, 3'b001, 5'd20, 32'd0, 4'b0010);
        send(32'd1, 32'd2, 3'b001, 5'd21, 32'd0, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_payload", {23'd0, result, flags, tag_out}, 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale_valid", {63'd0, out_valid}, 64'd0);
        end
        @(posedge clk);
        #1;

        // 6: reserved function codes
        send(32'd3, 32'd7, 3'b000, 5'd30, 32'd0, 4'b0010);
        send(32'd3, 32'd7, 3'b100, 5'd31, 32'd0, 4'b0010);
        drain();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
